// File: rtl/ddr_traffic_checker_if.sv
// rtl/ddr_traffic_checker_if.sv - user-interface bundle between traffic checker and memory controller
//
// Signals:
//   wr_valid / wr_ready / wr_payload  write request handshake and data
//   rd_ready / rd_valid / rd_payload  read request / data return handshake
//   address                           word address of the current request
//   sel                               byte enables
// Modports:
//   master  traffic checker side (drives requests)
//   slave   memory controller side
interface ddr_traffic_checker_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 27
);
  logic                wr_valid;
  logic                wr_ready;
  logic [DATA_W-1:0]   wr_payload;
  logic                rd_ready;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_payload;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] sel;

  modport master (
    output wr_valid, wr_payload, rd_ready, address, sel,
    input  wr_ready, rd_valid, rd_payload
  );

  modport slave (
    input  wr_valid, wr_payload, rd_ready, address, sel,
    output wr_ready, rd_valid, rd_payload
  );
endinterface

// File: rtl/ddr_traffic_checker.sv
// rtl/ddr_traffic_checker.sv - write-then-read pattern generator and checker (memory BIST)
//
// Ports:
//   clk              system clock
//   resetn           asynchronous active-low reset
//   start            one-cycle pulse, begins a pass when idle
//   mode             pattern: 0 index, 1 ~index, 2 walking one, 3 LFSR (sampled at start)
//   init_fin         controller initialisation complete (level)
//   mem              user-interface master: write/read handshakes, address, byte enables
//   busy             pass in progress
//   done             pass finished, held until next start
//   pass             valid with done, 1 = zero mismatches
//   err_count        mismatch count, saturating
//   first_err_addr   address of first mismatch
//   first_err_data   data read at first mismatch
module ddr_traffic_checker #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 27,
  parameter int                NUM_WORDS   = 32768,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [DATA_W-1:0] LFSR_TAPS   = 16'hB400,
  parameter logic [DATA_W-1:0] LFSR_SEED   = 16'h0001,
  parameter bit                STOP_ON_ERR = 1'b0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 init_fin,
  ddr_traffic_checker_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [DATA_W-1:0]    first_err_data
);

  localparam int IW = $clog2(NUM_WORDS + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     index_q, index_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [1:0]        mode_q, mode_d;
  logic              busy_d, done_d, pass_d;
  logic [15:0]       err_d;
  logic [ADDR_W-1:0] fe_addr_d;
  logic [DATA_W-1:0] fe_data_d;

  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] lfsr_step;
  logic [31:0]       bit_pos;
  logic              wr_xfer, rd_xfer, mismatch, last_word;

  // Pattern for the current word, from registered index/LFSR only.
  always_comb begin
    bit_pos = 32'(index_q) % 32'(DATA_W);
    case (mode_q)
      2'd0:    expected = DATA_W'(index_q);
      2'd1:    expected = ~DATA_W'(index_q);
      2'd2:    expected = DATA_W'(1) << bit_pos;
      default: expected = lfsr_q;
    endcase
  end

  // Galois step: shift right, fold taps in when the bit shifted out is 1.
  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);

  assign wr_xfer   = (state_q == S_WRITE) && mem.wr_ready;
  assign rd_xfer   = (state_q == S_READ) && mem.rd_valid;
  assign mismatch  = rd_xfer && (mem.rd_payload != expected);
  assign last_word = (index_q == LAST);

  assign mem.wr_valid   = (state_q == S_WRITE);
  assign mem.rd_ready   = (state_q == S_READ);
  assign mem.wr_payload = (state_q == S_WRITE) ? expected : '0;
  assign mem.address    = BASE_ADDR + ADDR_W'(index_q);
  assign mem.sel        = '1;

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    lfsr_d    = lfsr_q;
    mode_d    = mode_q;
    busy_d    = busy;
    done_d    = done;
    pass_d    = pass;
    err_d     = err_count;
    fe_addr_d = first_err_addr;
    fe_data_d = first_err_data;

    case (state_q)
      // DONE lasts one cycle with busy already low, so it accepts start like IDLE.
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d    = mode;
          err_d     = '0;
          fe_addr_d = '0;
          fe_data_d = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          index_d   = '0;
          lfsr_d    = LFSR_SEED;
          busy_d    = 1'b1;
          state_d   = S_WAIT_INIT;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_WAIT_INIT: begin
        if (init_fin) state_d = S_WRITE;
      end

      S_WRITE: begin
        if (wr_xfer) begin
          if (last_word) begin
            index_d = '0;
            lfsr_d  = LFSR_SEED;
            state_d = S_READ;
          end else begin
            index_d = index_q + 1'b1;
            lfsr_d  = lfsr_step;
          end
        end
      end

      S_READ: begin
        if (rd_xfer) begin
          if (mismatch) begin
            if (err_count != 16'hFFFF) err_d = err_count + 16'd1;
            if (err_count == 16'd0) begin
              fe_addr_d = mem.address;
              fe_data_d = mem.rd_payload;
            end
          end
          index_d = index_q + 1'b1;
          lfsr_d  = lfsr_step;
          if (last_word || (STOP_ON_ERR && mismatch)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 16'd0);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      index_q        <= '0;
      lfsr_q         <= LFSR_SEED;
      mode_q         <= 2'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      lfsr_q         <= lfsr_d;
      mode_q         <= mode_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_count      <= err_d;
      first_err_addr <= fe_addr_d;
      first_err_data <= fe_data_d;
    end
  end

endmodule

// File: tb/tb_ddr_traffic_checker.sv
// tb/tb_ddr_traffic_checker.sv - scoreboard bench for ddr_traffic_checker with loopback memory models
module tb_ddr_traffic_checker;
  localparam int AW = 27;
  localparam int DW = 16;
  localparam int NW = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- DUT 0: continue on error ----------------
  logic          start = 1'b0;
  logic          init_fin = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] fe_addr;
  logic [DW-1:0] fe_data;

  ddr_traffic_checker_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ddr_traffic_checker #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW), .BASE_ADDR(27'd0),
    .LFSR_TAPS(16'hB400), .LFSR_SEED(16'h0001), .STOP_ON_ERR(1'b0)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .init_fin(init_fin),
    .mem(bus), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(fe_addr), .first_err_data(fe_data)
  );

  logic [DW-1:0] mem0 [16];
  bit corrupt0 = 1'b0;
  always @(posedge clk) if (bus.wr_valid && bus.wr_ready) mem0[bus.address[3:0]] <= bus.wr_payload;
  assign bus.rd_payload = (corrupt0 && bus.address == AW'(5)) ? 16'hDEAD : mem0[bus.address[3:0]];

  // ---------------- DUT 1: stop on first error ----------------
  logic          start1 = 1'b0;
  logic          busy1, done1, pass1;
  logic [15:0]   err_count1;
  logic [AW-1:0] fe_addr1;
  logic [DW-1:0] fe_data1;

  ddr_traffic_checker_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  ddr_traffic_checker #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW), .BASE_ADDR(27'd0),
    .LFSR_TAPS(16'hB400), .LFSR_SEED(16'h0001), .STOP_ON_ERR(1'b1)
  ) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .mode(2'd0), .init_fin(1'b1),
    .mem(bus1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .first_err_addr(fe_addr1), .first_err_data(fe_data1)
  );

  logic [DW-1:0] mem1 [16];
  always @(posedge clk) if (bus1.wr_valid && bus1.wr_ready) mem1[bus1.address[3:0]] <= bus1.wr_payload;
  assign bus1.rd_payload = (bus1.address == AW'(5)) ? 16'hDEAD : mem1[bus1.address[3:0]];
  initial begin
    bus1.wr_ready = 1'b1;
    bus1.rd_valid = 1'b1;
  end

  // ---------------- handshake driver for DUT 0 ----------------
  int rdy_mode = 0;  // 0 = always ready, 1 = random, 2 = wr_ready toggles
  initial begin
    bus.wr_ready = 1'b1;
    bus.rd_valid = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: begin bus.wr_ready = 1'b1; bus.rd_valid = 1'b1; end
        1: begin bus.wr_ready = ($urandom % 3) != 0; bus.rd_valid = ($urandom % 3) != 0; end
        default: begin bus.wr_ready = ~bus.wr_ready; bus.rd_valid = 1'b1; end
      endcase
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [15:0]   errs;
    logic [AW-1:0] fa;
    logic [DW-1:0] fd;
    int            reads;
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];

  function automatic logic [DW-1:0] ref_data(input int m, input int i);
    logic [DW-1:0] v;
    case (m)
      0: v = DW'(i);
      1: v = ~DW'(i);
      2: v = DW'(1) << (i % DW);
      default: begin
        v = 16'h0001;
        for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
      end
    endcase
    return v;
  endfunction

  function automatic void push_pass(input int m, input bit corrupt);
    res_t r;
    wr_t  w;
    logic [DW-1:0] e, got;
    r.errs = 0; r.fa = 0; r.fd = 0; r.reads = NW;
    for (int i = 0; i < NW; i++) begin
      e = ref_data(m, i);
      w.addr = AW'(i);
      w.data = e;
      wr_q.push_back(w);
      got = (corrupt && i == 5) ? 16'hDEAD : e;
      if (got != e) begin
        if (r.errs == 0) begin r.fa = AW'(i); r.fd = got; end
        r.errs++;
      end
    end
    res_q.push_back(r);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_cnt = 0;
  int last_rd_cyc = 0;
  bit done_prev = 1'b0;
  bit hold_pending = 1'b0;
  logic [DW-1:0] hold_data;
  logic [AW-1:0] hold_addr;

  initial begin
    wr_t  w;
    res_t r;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        wr_q.delete();
        res_q.delete();
        rd_cnt = 0;
        hold_pending = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (hold_pending) begin
          check_eq("wr_hold_valid", 64'(bus.wr_valid), 64'd1);
          check_eq("wr_hold_data", 64'(bus.wr_payload), 64'(hold_data));
          check_eq("wr_hold_addr", 64'(bus.address), 64'(hold_addr));
          hold_pending = 1'b0;
        end
        if (bus.wr_valid && bus.wr_ready) begin
          check_eq("wr_expected", 64'(wr_q.size() != 0), 64'd1);
          if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            check_eq("wr_addr", 64'(bus.address), 64'(w.addr));
            check_eq("wr_data", 64'(bus.wr_payload), 64'(w.data));
            check_eq("wr_sel", 64'(bus.sel), 64'h3);
          end
        end else if (bus.wr_valid) begin
          hold_pending = 1'b1;
          hold_data = bus.wr_payload;
          hold_addr = bus.address;
        end
        if (bus.rd_ready && bus.rd_valid) begin
          rd_cnt++;
          last_rd_cyc = cyc;
        end
        if (done && !done_prev) begin
          check_eq("res_expected", 64'(res_q.size() != 0), 64'd1);
          if (res_q.size() != 0) begin
            r = res_q.pop_front();
            check_eq("err_count", 64'(err_count), 64'(r.errs));
            check_eq("pass", 64'(pass), 64'(r.errs == 0));
            check_eq("first_err_addr", 64'(fe_addr), 64'(r.fa));
            check_eq("first_err_data", 64'(fe_data), 64'(r.fd));
            check_eq("read_count", 64'(rd_cnt), 64'(r.reads));
            check_eq("writes_left", 64'(wr_q.size()), 64'd0);
            check_eq("done_latency", 64'(cyc - last_rd_cyc), 64'd1);
            check_eq("busy_at_done", 64'(busy), 64'd0);
          end
          rd_cnt = 0;
        end
        done_prev = done;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_pass(input int m, input bit corrupt, input int rmode, input int init_delay);
    int n;
    int wv;
    rdy_mode = rmode;
    corrupt0 = corrupt;
    push_pass(m, corrupt);
    init_fin = (init_delay == 0);
    @(posedge clk);
    #1;
    mode = 2'(m);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = ~mode;  // must be ignored: mode was latched at start
    if (init_delay == 0) begin
      @(negedge clk);
      check_eq("lat_wait_init", 64'(bus.wr_valid), 64'd0);
      @(negedge clk);
      check_eq("lat_first_write", 64'(bus.wr_valid), 64'd1);
    end else begin
      wv = 0;
      for (int k = 0; k < init_delay; k++) begin
        @(negedge clk);
        if (bus.wr_valid) wv++;
        start = (k == 10);  // second start while busy
      end
      start = 1'b0;
      check_eq("no_write_before_init", 64'(wv), 64'd0);
      check_eq("busy_waiting_init", 64'(busy), 64'd1);
      init_fin = 1'b1;
    end
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (init_delay != 0 && n == 5) init_fin = 1'b0;  // falling init_fin mid-pass is ignored
    end
    check_eq("done_timeout", 64'(done), 64'd1);
    repeat (2) @(negedge clk);
    check_eq("done_hold", 64'(done), 64'd1);
    check_eq("idle_not_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int rd1;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int rd1;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_address", 64'(bus.address), 64'd0);
    check_eq("rst_sel", 64'(bus.sel), 64'h3);
    check_eq("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    check_eq("rst_wr_payload", 64'(bus.wr_payload), 64'd0);
    check_eq("rst_rd_ready", 64'(bus.rd_ready), 64'd0);
    check_eq("rst_status", 64'({busy, done, pass}), 64'd0);
    check_eq("rst_err", 64'({err_count, fe_addr, fe_data}), 64'd0);
    @(posedge clk);
    #2;
    resetn = 1'b1;

    // STOP_ON_ERR instance: corrupt word 5 ends the pass after the 6th read.
    @(posedge clk);
    #1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    n = 0;
    rd1 = 0;
    while (!done1 && n < 500) begin
      @(negedge clk);
      if (bus1.rd_ready && bus1.rd_valid) rd1++;
      n++;
    end
    check_eq("stop_done", 64'(done1), 64'd1);
    check_eq("stop_reads", 64'(rd1), 64'd6);
    check_eq("stop_err_count", 64'(err_count1), 64'd1);
    check_eq("stop_pass", 64'(pass1), 64'd0);
    check_eq("stop_fe_addr", 64'(fe_addr1), 64'd5);
    check_eq("stop_fe_data", 64'(fe_data1), 64'hDEAD);
    check_eq("stop_rd_ready", 64'(bus1.rd_ready), 64'd0);
    check_eq("stop_busy", 64'(busy1), 64'd0);

    // Directed passes on the continue-on-error instance.
    run_pass(0, 1'b0, 0, 0);
    run_pass(3, 1'b0, 1, 0);
    run_pass(0, 1'b1, 0, 0);
    run_pass(2, 1'b0, 2, 50);

    // Randomized passes.
    for (int p = 0; p < 6; p++) begin
      run_pass(int'($urandom % 4), ($urandom % 2) == 1, 1 + int'($urandom % 2), 0);
    end

    // Reset during READ at index 3.
    rdy_mode = 0;
    corrupt0 = 1'b0;
    init_fin = 1'b1;
    push_pass(1, 1'b0);
    @(posedge clk);
    #1;
    mode = 2'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (rd_cnt < 3 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("rst_reach_read", 64'(rd_cnt), 64'd3);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_address", 64'(bus.address), 64'd0);
    check_eq("mid_rst_rd_ready", 64'(bus.rd_ready), 64'd0);
    check_eq("mid_rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    check_eq("mid_rst_status", 64'({busy, done, pass}), 64'd0);
    check_eq("mid_rst_err", 64'({err_count, fe_addr, fe_data}), 64'd0);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    run_pass(1, 1'b0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr_traffic_checker.md
Name: ddr_traffic_checker

Overview:
- Synthesizable write-then-read traffic generator and checker for the slowDDR3 user interface.
- Waits for controller init, writes NUM_WORDS words of a selectable pattern from BASE_ADDR upward, reads them back and compares each word.
- Reports pass/fail, error count and first-failure detail.
- Replaces the fixed incrementing-count bench stimulus; usable on silicon as a memory BIST.

Parameters:
- DATA_W, 16: payload width; multiple of 8.
- ADDR_W, 27: user address width.
- NUM_WORDS, 32768: words per pass; >= 1.
- BASE_ADDR, 0: address of word 0.
- LFSR_TAPS, 16'hB400: Galois feedback mask for mode 3, DATA_W bits.
- LFSR_SEED, 16'h0001: nonzero mode-3 seed, DATA_W bits.
- STOP_ON_ERR, 0: 1 = abort to DONE on first mismatch.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a pass when idle.
- mode  in  2  0 = index, 1 = ~index, 2 = walking one, 3 = LFSR; sampled at start.
- init_fin  in  1  controller initialisation complete (level).
- wr_valid  out  1  write request.
- wr_ready  in  1  write accepted this cycle.
- wr_payload  out  DATA_W  write data.
- rd_ready  out  1  read request / data sink ready.
- rd_valid  in  1  read data valid.
- rd_payload  in  DATA_W  read data.
- address  out  ADDR_W  BASE_ADDR + current index.
- sel  out  DATA_W/8  byte enables; all ones.
- busy  out  1  pass in progress.
- done  out  1  pass finished; held until next start.
- pass  out  1  valid when done; 1 = zero errors.
- err_count  out  16  mismatches; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of first mismatch.
- first_err_data  out  DATA_W  data read at first mismatch.

Behaviour:
- Reset values:
  - All outputs 0 except sel = all ones and address = BASE_ADDR.
  - State IDLE; index 0; LFSR = LFSR_SEED.
- Index width: clog2(NUM_WORDS+1). address = BASE_ADDR + index, truncated to ADDR_W (wraps).
- Expected data for index i:
  - mode 0: i[DATA_W-1:0].
  - mode 1: ~i[DATA_W-1:0].
  - mode 2: 1 << (i mod DATA_W).
  - mode 3: current LFSR value.
  - LFSR advances one step per accepted transfer: shift right; XOR LFSR_TAPS when bit0 = 1.
- FSM: IDLE -> WAIT_INIT -> WRITE -> READ -> DONE.
- IDLE:
  - start = 1: latch mode; clear err_count, first_err_*, done, pass; index = 0; LFSR = seed; busy = 1.
  - Go to WAIT_INIT.
- WAIT_INIT:
  - Go to WRITE on the first cycle init_fin = 1.
  - If init_fin is already 1, leave after exactly one cycle.
- WRITE:
  - wr_valid = 1; wr_payload = expected(index), combinational from registered index/LFSR.
  - Transfer = wr_valid & wr_ready; on each transfer, index + 1 and LFSR step.
  - Transfer at index NUM_WORDS-1: index = 0, LFSR = seed, wr_valid = 0 next cycle, go to READ.
  - No write while wr_ready = 0; the payload holds.
- READ:
  - rd_ready = 1; transfer = rd_valid & rd_ready.
  - On each transfer, compare rd_payload with expected(index). On mismatch:
    - err_count + 1, saturating.
    - If this is the first error, capture first_err_addr = address and first_err_data = rd_payload.
  - Then index + 1 and LFSR step.
  - Transfer at index NUM_WORDS-1: go to DONE.
  - STOP_ON_ERR = 1 and mismatch: go to DONE immediately.
  - rd_valid while not in READ is ignored (no compare, no count).
- DONE:
  - busy = 0; done = 1; pass = (err_count == 0).
  - Go to IDLE the same cycle so the next start is accepted; done and pass hold until that start.
- start while busy: ignored. mode changes mid-pass: ignored.
- init_fin falling mid-pass: ignored; the pass continues.
- resetn low at any time: immediate return to reset values; an in-flight request is dropped.
- Latency: first wr_valid appears 2 cycles after start when init_fin = 1; done rises 1 cycle after the last read transfer.

Test Plan:
- Mode 0, NUM_WORDS = 8, wr_ready tied 1, ideal loopback memory, start with init_fin = 1 -> 8 writes of data 0..7 at addresses 0..7, then 8 reads; done = 1, pass = 1, err_count = 0.
- Mode 3, seed 16'h0001, taps 16'hB400 -> write data 0001, B400, 5A00, 2D00; read-back checks the same sequence; pass = 1.
- Memory corrupts word at address 5 to 16'hDEAD, STOP_ON_ERR = 0 -> err_count = 1, first_err_addr = 5, first_err_data = 16'hDEAD, pass = 0, all 8 reads completed.
- Same corruption, STOP_ON_ERR = 1 -> done after the 6th read transfer, rd_ready deasserts, err_count = 1.
- init_fin held 0 for 50 cycles after start, wr_ready toggled every other cycle -> no wr_valid for 50 cycles; each payload holds until accepted; second start while busy has no effect.
- resetn pulsed low during READ at index 3 -> all outputs return to reset values immediately; a new start then completes with pass = 1.
